// File: rtl/conv_core_pkg.sv
// conv_core_pkg: shared types and helpers for the parametrised convolution core.
//   - state_t      : top-level FSM states
//   - DEF_*        : default sizes and the address widths derived from them
//   - out_dim      : output extent along one axis (valid or same-padded)
//   - cfg_ok       : command-time configuration check
//   - sat_relu     : saturation to a DW-bit signed range with optional ReLU
package conv_core_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_LD_W, S_LD_B, S_LD_I, S_CALC, S_OUT, S_DONE
    } state_t;

    localparam int DEF_DW       = 16;
    localparam int DEF_FRAC     = 10;
    localparam int DEF_ACCW     = 40;
    localparam int DEF_KMAX     = 5;
    localparam int DEF_IF_DEPTH = 32768;
    localparam int DEF_W_DEPTH  = 32768;
    localparam int DEF_OF_DEPTH = 32768;
    localparam int DEF_B_DEPTH  = 1024;
    localparam int DEF_IF_AW    = $clog2(DEF_IF_DEPTH);
    localparam int DEF_W_AW     = $clog2(DEF_W_DEPTH);
    localparam int DEF_OF_AW    = $clog2(DEF_OF_DEPTH);
    localparam int DEF_B_AW     = $clog2(DEF_B_DEPTH);

    // Output extent: valid convolution spans n-k, same padding spans n-1.
    function automatic int out_dim(input int n, input int k, input logic s, input logic pad);
        int span;
        span = pad ? (n - 1) : (n - k);
        return (s ? (span >>> 1) : span) + 1;
    endfunction

    function automatic logic cfg_ok(input int k, input int ic, input int oc,
                                    input int h, input int w, input logic s, input logic pad,
                                    input int kmax, input int w_depth, input int if_depth,
                                    input int of_depth, input int b_depth);
        longint nw, ni, no;
        if (ic == 0 || oc == 0 || h == 0 || w == 0) return 1'b0;
        if (k[0] == 1'b0 || k > kmax) return 1'b0;
        if (!pad && (k > h || k > w)) return 1'b0;
        nw = longint'(oc) * longint'(ic) * longint'(k) * longint'(k);
        ni = longint'(ic) * longint'(h) * longint'(w);
        no = longint'(oc) * longint'(out_dim(h, k, s, pad)) * longint'(out_dim(w, k, s, pad));
        if (nw > longint'(w_depth) || ni > longint'(if_depth) || no > longint'(of_depth)) return 1'b0;
        if (oc > b_depth) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v, input int dw,
                                                   input logic relu);
        logic signed [63:0] hi, lo, r;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        r  = (v > hi) ? hi : ((v < lo) ? lo : v);
        if (relu && r < 0) r = '0;
        return r;
    endfunction

endpackage

// File: rtl/conv_core_param_mac.sv
// conv_mac: multiply-accumulate and result stage for one output pixel.
// Control (issue_*) is presented in the cycle the buffer addresses are issued;
// the operands a/b arrive one cycle later from the registered buffer reads.
// The result is valid exactly 2 cycles after the issue_last cycle.
// Ports: clk, rst, issue_valid/first/last, a, b (operands), bias, bias_en,
//        relu_en, res_valid, res_data.
module conv_mac
    import conv_core_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int FRAC = DEF_FRAC,
    parameter int ACCW = DEF_ACCW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic          issue_first,
    input  logic          issue_last,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] bias,
    input  logic          bias_en,
    input  logic          relu_en,
    output logic          res_valid,
    output logic [DW-1:0] res_data
);

    logic                   v_reg, first_reg, last_reg, done_reg;
    logic signed [ACCW-1:0] acc_reg;
    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] prod_ext, bias_ext, biased, shifted;
    logic signed [63:0]     sat_val;

    always_comb begin
        prod     = $signed(a) * $signed(b);
        prod_ext = ACCW'(prod);
        // Bias is a DW-bit fixed-point value; align it to the product scale.
        bias_ext = bias_en ? (ACCW'($signed(bias)) <<< FRAC) : '0;
        biased   = acc_reg + bias_ext;
        shifted  = biased >>> FRAC;
        sat_val  = sat_relu(64'(shifted), DW, relu_en);
        res_data = sat_val[DW-1:0];
    end

    assign res_valid = done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_reg     <= 1'b0;
            first_reg <= 1'b0;
            last_reg  <= 1'b0;
            done_reg  <= 1'b0;
            acc_reg   <= '0;
        end else begin
            v_reg     <= issue_valid;
            first_reg <= issue_valid && issue_first;
            last_reg  <= issue_valid && issue_last;
            done_reg  <= last_reg;
            // First product of an output restarts the sum instead of adding.
            if (v_reg) acc_reg <= (first_reg ? '0 : acc_reg) + prod_ext;
        end
    end

endmodule

// File: rtl/conv_core_param.sv
// conv_core_param: KxK convolution core, one MAC per cycle.
// Loads weights (+bias) and an input map over din, computes into an output
// buffer, then streams the output buffer over a valid/ready port.
// Ports: clk, rst (sync, active-high), din_valid/din_data, dout_valid/
//        dout_ready/dout_data, load_weight/load_input/store_output commands,
//        has_bias, relu_en, stride, K, Iext, Oext, Hext, Wext, busy,
//        calc_done, cfg_err.
// Optional: CONV_SAME_PAD_EN adds input pad_en for same-size (zero padded) output.
module conv_core_param
    import conv_core_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int FRAC     = DEF_FRAC,
    parameter int ACCW     = DEF_ACCW,
    parameter int KMAX     = DEF_KMAX,
    parameter int IF_DEPTH = DEF_IF_DEPTH,
    parameter int W_DEPTH  = DEF_W_DEPTH,
    parameter int OF_DEPTH = DEF_OF_DEPTH,
    parameter int B_DEPTH  = DEF_B_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din_valid,
    input  logic [DW-1:0] din_data,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [DW-1:0] dout_data,
    input  logic          load_weight,
    input  logic          load_input,
    input  logic          store_output,
    input  logic          has_bias,
    input  logic          relu_en,
    input  logic          stride,
    input  logic [2:0]    K,
    input  logic [10:0]   Iext,
    input  logic [10:0]   Oext,
    input  logic [7:0]    Hext,
    input  logic [7:0]    Wext,
`ifdef CONV_SAME_PAD_EN
    input  logic          pad_en,
`endif
    output logic          busy,
    output logic          calc_done,
    output logic          cfg_err
);

    localparam int IF_AW = $clog2(IF_DEPTH);
    localparam int W_AW  = $clog2(W_DEPTH);
    localparam int OF_AW = $clog2(OF_DEPTH);
    localparam int B_AW  = $clog2(B_DEPTH);

    logic pad_in;
`ifdef CONV_SAME_PAD_EN
    assign pad_in = pad_en;
`else
    assign pad_in = 1'b0;
`endif

    state_t state_reg;
    // Configuration captured when a command is accepted.
    int   k_reg, ic_reg, oc_reg, h_reg, w_reg;
    logic s_reg, bias_reg, relu_reg, pad_reg;
    int   ld_cnt, mac_cnt, kx_cnt, ky_cnt, ic_cnt, ox_cnt, oy_cnt, o_cnt, out_idx, w_base;
    int   rd_ptr, xfer_cnt;
    logic dout_valid_reg, calc_done_reg, cfg_err_reg, zero_d1_reg;

    int   ho, wo, nw, ni, no, n_mac, stride_step, off, iy, ix, if_lin;
    logic tap_pad, issue_valid, issue_first, issue_last, rd_en, xfer, cmd_ok;

    logic [DW-1:0] w_mem  [W_DEPTH];
    logic [DW-1:0] b_mem  [B_DEPTH];
    logic [DW-1:0] if_mem [IF_DEPTH];
    logic [DW-1:0] of_mem [OF_DEPTH];
    logic [DW-1:0] w_rdata, b_rdata, if_rdata, of_rdata, mac_a, mac_res;
    logic          mac_res_valid;

    always_comb begin
        cmd_ok = cfg_ok(int'(K), int'(Iext), int'(Oext), int'(Hext), int'(Wext), stride, pad_in,
                        KMAX, W_DEPTH, IF_DEPTH, OF_DEPTH, B_DEPTH);
        ho          = out_dim(h_reg, k_reg, s_reg, pad_reg);
        wo          = out_dim(w_reg, k_reg, s_reg, pad_reg);
        nw          = oc_reg * ic_reg * k_reg * k_reg;
        ni          = ic_reg * h_reg * w_reg;
        no          = oc_reg * ho * wo;
        n_mac       = ic_reg * k_reg * k_reg;
        stride_step = s_reg ? 2 : 1;
        off         = pad_reg ? (k_reg - 1) / 2 : 0;
        iy          = oy_cnt * stride_step + ky_cnt - off;
        ix          = ox_cnt * stride_step + kx_cnt - off;
        // Only reachable with padding; padded taps skip the ifmap read.
        tap_pad     = (iy < 0) || (iy >= h_reg) || (ix < 0) || (ix >= w_reg);
        if_lin      = (ic_cnt * h_reg + iy) * w_reg + ix;
        issue_valid = (state_reg == S_CALC) && (mac_cnt < n_mac);
        issue_first = (mac_cnt == 0);
        issue_last  = (mac_cnt == n_mac - 1);
        xfer        = dout_valid_reg && dout_ready;
        // Fetch the next word whenever the output register is empty or draining.
        rd_en       = (state_reg == S_OUT) && (rd_ptr < no) && (!dout_valid_reg || dout_ready);
        mac_a       = zero_d1_reg ? '0 : if_rdata;
    end

    always_ff @(posedge clk) begin
        if (state_reg == S_LD_W && din_valid) w_mem[W_AW'(ld_cnt)] <= din_data;
        if (issue_valid) w_rdata <= w_mem[W_AW'(w_base + mac_cnt)];
    end

    always_ff @(posedge clk) begin
        if (state_reg == S_LD_B && din_valid) b_mem[B_AW'(ld_cnt)] <= din_data;
        b_rdata <= b_mem[B_AW'(o_cnt)];
    end

    always_ff @(posedge clk) begin
        if (state_reg == S_LD_I && din_valid) if_mem[IF_AW'(ld_cnt)] <= din_data;
        if (issue_valid && !tap_pad) if_rdata <= if_mem[IF_AW'(if_lin)];
    end

    always_ff @(posedge clk) begin
        if (mac_res_valid) of_mem[OF_AW'(out_idx)] <= mac_res;
        if (rd_en) of_rdata <= of_mem[OF_AW'(rd_ptr)];
    end

    conv_mac #(.DW(DW), .FRAC(FRAC), .ACCW(ACCW)) u_mac (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_first(issue_first),
        .issue_last (issue_last),
        .a          (mac_a),
        .b          (w_rdata),
        .bias       (b_rdata),
        .bias_en    (bias_reg),
        .relu_en    (relu_reg),
        .res_valid  (mac_res_valid),
        .res_data   (mac_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            k_reg <= 0; ic_reg <= 0; oc_reg <= 0; h_reg <= 0; w_reg <= 0;
            s_reg <= 1'b0; bias_reg <= 1'b0; relu_reg <= 1'b0; pad_reg <= 1'b0;
            ld_cnt <= 0; mac_cnt <= 0; kx_cnt <= 0; ky_cnt <= 0; ic_cnt <= 0;
            ox_cnt <= 0; oy_cnt <= 0; o_cnt <= 0; out_idx <= 0; w_base <= 0;
            rd_ptr <= 0; xfer_cnt <= 0;
            dout_valid_reg <= 1'b0;
            calc_done_reg  <= 1'b0;
            cfg_err_reg    <= 1'b0;
            zero_d1_reg    <= 1'b0;
        end else begin
            calc_done_reg <= 1'b0;
            zero_d1_reg   <= issue_valid && tap_pad;
            unique case (state_reg)
                S_IDLE: begin
                    if (load_weight || load_input || store_output) begin
                        if (cmd_ok) begin
                            k_reg <= int'(K); ic_reg <= int'(Iext); oc_reg <= int'(Oext);
                            h_reg <= int'(Hext); w_reg <= int'(Wext);
                            s_reg <= stride; bias_reg <= has_bias; relu_reg <= relu_en;
                            pad_reg <= pad_in;
                            cfg_err_reg <= 1'b0;
                            ld_cnt <= 0; rd_ptr <= 0; xfer_cnt <= 0;
                            if (load_weight)     state_reg <= S_LD_W;
                            else if (load_input) state_reg <= S_LD_I;
                            else                 state_reg <= S_OUT;
                        end else begin
                            cfg_err_reg <= 1'b1;
                        end
                    end
                end
                S_LD_W: if (din_valid) begin
                    if (ld_cnt == nw - 1) begin
                        ld_cnt    <= 0;
                        state_reg <= bias_reg ? S_LD_B : S_DONE;
                    end else ld_cnt <= ld_cnt + 1;
                end
                S_LD_B: if (din_valid) begin
                    if (ld_cnt == oc_reg - 1) begin
                        ld_cnt    <= 0;
                        state_reg <= S_DONE;
                    end else ld_cnt <= ld_cnt + 1;
                end
                S_LD_I: if (din_valid) begin
                    if (ld_cnt == ni - 1) begin
                        ld_cnt <= 0; mac_cnt <= 0; kx_cnt <= 0; ky_cnt <= 0; ic_cnt <= 0;
                        ox_cnt <= 0; oy_cnt <= 0; o_cnt <= 0; out_idx <= 0; w_base <= 0;
                        state_reg <= S_CALC;
                    end else ld_cnt <= ld_cnt + 1;
                end
                S_CALC: begin
                    // mac_cnt: 0..n_mac-1 issue, n_mac drain, n_mac+1 writeback.
                    if (mac_cnt == n_mac + 1) begin
                        mac_cnt <= 0; kx_cnt <= 0; ky_cnt <= 0; ic_cnt <= 0;
                        out_idx <= out_idx + 1;
                        if (ox_cnt == wo - 1) begin
                            ox_cnt <= 0;
                            if (oy_cnt == ho - 1) begin
                                oy_cnt <= 0;
                                o_cnt  <= o_cnt + 1;
                                w_base <= w_base + n_mac;
                            end else oy_cnt <= oy_cnt + 1;
                        end else ox_cnt <= ox_cnt + 1;
                        if (out_idx == no - 1) begin
                            calc_done_reg <= 1'b1;
                            state_reg     <= S_DONE;
                        end
                    end else begin
                        mac_cnt <= mac_cnt + 1;
                        if (mac_cnt < n_mac) begin
                            if (kx_cnt == k_reg - 1) begin
                                kx_cnt <= 0;
                                if (ky_cnt == k_reg - 1) begin
                                    ky_cnt <= 0;
                                    ic_cnt <= ic_cnt + 1;
                                end else ky_cnt <= ky_cnt + 1;
                            end else kx_cnt <= kx_cnt + 1;
                        end
                    end
                end
                S_OUT: begin
                    if (rd_en) rd_ptr <= rd_ptr + 1;
                    if (rd_en)     dout_valid_reg <= 1'b1;
                    else if (xfer) dout_valid_reg <= 1'b0;
                    if (xfer) begin
                        xfer_cnt <= xfer_cnt + 1;
                        if (xfer_cnt == no - 1) state_reg <= S_DONE;
                    end
                end
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy       = (state_reg != S_IDLE);
    assign dout_valid = dout_valid_reg;
    assign dout_data  = of_rdata;
    assign calc_done  = calc_done_reg;
    assign cfg_err    = cfg_err_reg;

endmodule

// File: tb/tb_conv_core_param.sv
// Directed testbench for conv_core_param: loads small maps/kernels, checks
// calc latency, streamed outputs (with and without backpressure), config
// rejection and mid-operation reset.
module tb_conv_core_param;

    logic        clk = 1'b0;
    logic        rst, din_valid, dout_valid, dout_ready;
    logic [15:0] din_data, dout_data;
    logic        load_weight, load_input, store_output, has_bias, relu_en, stride;
    logic [2:0]  K;
    logic [10:0] Iext, Oext;
    logic [7:0]  Hext, Wext;
    logic        busy, calc_done, cfg_err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] words[$];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    always #5 clk = ~clk;

    conv_core_param dut (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .din_data    (din_data),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_data   (dout_data),
        .load_weight (load_weight),
        .load_input  (load_input),
        .store_output(store_output),
        .has_bias    (has_bias),
        .relu_en     (relu_en),
        .stride      (stride),
        .K           (K),
        .Iext        (Iext),
        .Oext        (Oext),
        .Hext        (Hext),
        .Wext        (Wext),
`ifdef CONV_SAME_PAD_EN
        .pad_en      (1'b0),
`endif
        .busy        (busy),
        .calc_done   (calc_done),
        .cfg_err     (cfg_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int k, input int ic, input int oc, input int h, input int w,
                           input bit s, input bit bias, input bit relu);
        K = 3'(k); Iext = 11'(ic); Oext = 11'(oc); Hext = 8'(h); Wext = 8'(w);
        stride = s; has_bias = bias; relu_en = relu;
    endtask

    // which: 0 load_weight, 1 load_input, 2 store_output
    task automatic issue(input int which);
        load_weight  = (which == 0);
        load_input   = (which == 1);
        store_output = (which == 2);
        step();
        load_weight = 1'b0; load_input = 1'b0; store_output = 1'b0;
    endtask

    task automatic fill(input int n, input logic [15:0] v);
        words.delete();
        for (int j = 0; j < n; j++) words.push_back(v);
    endtask

    task automatic stream_words();
        foreach (words[j]) begin
            din_valid = 1'b1;
            din_data  = words[j];
            step();
        end
        din_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 5000) begin
            step();
            n++;
        end
        check({tag, " idle"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic load_weights(input string tag);
        issue(0);
        stream_words();
        wait_idle(tag);
    endtask

    // Load the input map (words) and measure edges until calc_done.
    task automatic compute(input string tag, input int exp_cycles);
        int cyc = 0;
        issue(1);
        stream_words();
        do begin
            step();
            cyc++;
        end while (!calc_done && cyc < 5000);
        check({tag, " calc cycles"}, 32'(cyc), 32'(exp_cycles));
        wait_idle(tag);
    endtask

    task automatic run_store(input string tag, input bit rnd);
        int n = 0;
        logic v, r;
        logic [15:0] d;
        got_q.delete();
        issue(2);
        while (busy && n < 2000) begin
            v = dout_valid;
            d = dout_data;
            if (!rnd && n == 0) check({tag, " valid cyc1"}, {31'b0, v}, 32'd0);
            if (!rnd && n == 1) check({tag, " valid cyc2"}, {31'b0, v}, 32'd1);
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            dout_ready = r;
            step();
            n++;
            if (v && r) got_q.push_back(d);
            else if (v) begin
                check({tag, " stall valid"}, {31'b0, dout_valid}, 32'd1);
                check({tag, " stall data"}, {16'b0, dout_data}, {16'b0, d});
            end
        end
        dout_ready = 1'b0;
        check({tag, " done idle"}, {31'b0, busy}, 32'd0);
        check({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
            check($sformatf("%s word%0d", tag, j), {16'b0, got_q[j]}, {16'b0, exp_q[j]});
    endtask

    initial begin
        rst = 1'b1; din_valid = 1'b0; din_data = '0; dout_ready = 1'b0;
        load_weight = 1'b0; load_input = 1'b0; store_output = 1'b0;
        set_cfg(3, 1, 1, 4, 4, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        rst = 1'b0;
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst dout_valid", {31'b0, dout_valid}, 32'd0);
        check("rst calc_done", {31'b0, calc_done}, 32'd0);
        check("rst cfg_err", {31'b0, cfg_err}, 32'd0);

        // All ones (1.0): 3x3 sum = 9.0 = 0x2400; 4 outputs, 4*(9+2) cycles.
        set_cfg(3, 1, 1, 4, 4, 1'b0, 1'b0, 1'b0);
        fill(9, 16'h0400);  load_weights("t1 w");
        fill(16, 16'h0400); compute("t1", 44);
        exp_q = {16'h2400, 16'h2400, 16'h2400, 16'h2400};
        run_store("t1", 1'b0);

        // Zero weights, bias -1.0: ReLU gives 0, otherwise 0xFC00.
        set_cfg(3, 1, 1, 4, 4, 1'b0, 1'b1, 1'b1);
        fill(9, 16'h0000); words.push_back(16'hFC00); load_weights("t2 w");
        fill(16, 16'h0400); compute("t2 relu", 44);
        exp_q = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
        run_store("t2 relu", 1'b0);
        set_cfg(3, 1, 1, 4, 4, 1'b0, 1'b1, 1'b0);
        compute("t2 norelu", 44);
        exp_q = {16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00};
        run_store("t2 norelu", 1'b0);

        // Saturation both ways.
        set_cfg(3, 1, 1, 4, 4, 1'b0, 1'b0, 1'b0);
        fill(9, 16'h7FFF);  load_weights("t3 w+");
        fill(16, 16'h7FFF); compute("t3 pos", 44);
        exp_q = {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        run_store("t3 pos", 1'b0);
        fill(9, 16'h8001);  load_weights("t3 w-");
        fill(16, 16'h7FFF); compute("t3 neg", 44);
        exp_q = {16'h8000, 16'h8000, 16'h8000, 16'h8000};
        run_store("t3 neg", 1'b0);

        // Stride 2, 5x5 map in[y][x]=5y+x (raw), O=2: o0 all-ones kernel,
        // o1 single tap at ky=0,kx=2 -> 2x2x2 = 8 words.
        set_cfg(3, 1, 2, 5, 5, 1'b1, 1'b0, 1'b0);
        fill(18, 16'h0000);
        for (int j = 0; j < 9; j++) words[j] = 16'h0400;
        words[9 + 2] = 16'h0400;
        load_weights("t4 w");
        words.delete();
        for (int j = 0; j < 25; j++) words.push_back(16'(j));
        compute("t4", 88);
        exp_q = {16'd54, 16'd72, 16'd144, 16'd162, 16'd2, 16'd4, 16'd12, 16'd14};
        run_store("t4 ready1", 1'b0);
        run_store("t4 random", 1'b1);

        // Rejected configurations.
        set_cfg(4, 1, 1, 4, 4, 1'b0, 1'b0, 1'b0);
        issue(0);
        check("k4 cfg_err", {31'b0, cfg_err}, 32'd1);
        check("k4 busy", {31'b0, busy}, 32'd0);
        step();
        check("k4 busy later", {31'b0, busy}, 32'd0);
        set_cfg(5, 100, 100, 5, 5, 1'b0, 1'b0, 1'b0);
        issue(0);
        check("nw cfg_err", {31'b0, cfg_err}, 32'd1);
        check("nw busy", {31'b0, busy}, 32'd0);
        set_cfg(3, 0, 1, 4, 4, 1'b0, 1'b0, 1'b0);
        issue(1);
        check("i0 cfg_err", {31'b0, cfg_err}, 32'd1);
        // A valid store clears cfg_err and replays the stride-2 results.
        set_cfg(3, 1, 2, 5, 5, 1'b1, 1'b0, 1'b0);
        run_store("restore", 1'b0);
        check("cfg_err cleared", {31'b0, cfg_err}, 32'd0);

        // Reset in the middle of CALC, then a full clean run.
        set_cfg(3, 1, 1, 4, 4, 1'b0, 1'b0, 1'b0);
        fill(16, 16'h0400);
        issue(1);
        stream_words();
        repeat (5) step();
        check("midcalc busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        step();
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort dout_valid", {31'b0, dout_valid}, 32'd0);
        check("abort calc_done", {31'b0, calc_done}, 32'd0);
        rst = 1'b0;
        step();
        fill(9, 16'h0400);  load_weights("t7 w");
        fill(16, 16'h0400); compute("t7", 44);
        exp_q = {16'h2400, 16'h2400, 16'h2400, 16'h2400};
        run_store("t7", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
